// File: rtl/count_checker.sv
// count_checker: receive-side monitor for a free-running up-counter.
// Locks onto an incrementing sequence, flags discontinuities while locked,
// keeps a saturating error tally and marks each locked wrap to all-ones.
module count_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             sample_en,
  input  logic             err_clr,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_V  = 8'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       good_run_q, good_run_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] expected_q, expected_d;

  // Next-state: sequence tracking, pulse generation and error tally.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    locked_d   = locked_q;
    mismatch_d = 1'b0;
    wrap_d     = 1'b0;
    expected_d = expected_q;
    err_d      = err_q;

    if (sample_en) begin
      // The prediction is refreshed on every enabled sample, in every state.
      expected_d = count_in + CNT_ONE;
      case (state_q)
        ST_UNLOCKED: begin
          // First sample only seeds the prediction; nothing to compare yet.
          state_d    = ST_ACQUIRE;
          good_run_d = 8'd0;
        end
        ST_ACQUIRE: begin
          if (count_in == expected_q) begin
            good_run_d = good_run_q + 8'd1;
            if (good_run_d == LOCK_V) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d  = ST_ACQUIRE;
            end
          end else begin
            // Errors during acquisition only restart the run; they are not counted.
            good_run_d = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (count_in == expected_q) begin
            wrap_d = (count_in == CNT_MAX);
          end else begin
            mismatch_d = 1'b1;
            locked_d   = 1'b0;
            good_run_d = 8'd0;
            state_d    = ST_ACQUIRE;
          end
        end
        default: begin
          state_d    = ST_UNLOCKED;
          good_run_d = 8'd0;
          locked_d   = 1'b0;
        end
      endcase
    end else begin
      expected_d = expected_q;
    end

    // A clear coinciding with a new error keeps that error.
    if (err_clr) begin
      err_d = mismatch_d ? ERR_ONE : {ERR_W{1'b0}};
    end else if (mismatch_d && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_ONE;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      good_run_q <= 8'd0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= {ERR_W{1'b0}};
      expected_q <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      expected_q <= expected_d;
    end
  end

  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign wrap_pulse = wrap_q;
  assign err_count  = err_q;
  assign expected   = expected_q;

endmodule
